// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with tree-PLRU replacement.
// Optional event counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_nway #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 4,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned s_line   = 8 * (2 ** s_offset)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [31:0]       up_address,
  input  logic [s_line-1:0] up_wdata,
  output logic [s_line-1:0] up_rdata,
  output logic              up_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss,
  output logic [31:0]       perf_wb
);
  localparam int unsigned SETS = 2 ** s_index;
  localparam int unsigned WW   = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WB, FILL} state_t;
  state_t r_state, w_next;

  logic [31:s_offset] r_addr;
  logic               r_is_write, r_first;
  logic [s_line-1:0]  r_wdata;
  logic [WW-1:0]      r_victim;
  logic               r_mem_read, r_mem_write;
  logic [31:0]        r_mem_addr;
  logic [s_line-1:0]  r_mem_wdata;

  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [WAYS-1:1]    r_plru  [SETS];
  logic [s_tag-1:0]   r_tag   [WAYS][SETS];
  logic [s_line-1:0]  r_data  [WAYS][SETS];
  logic [s_tag-1:0]   r_tag_q [WAYS];
  logic [s_line-1:0]  r_data_q[WAYS];

  logic [s_index-1:0] w_index;
  logic [s_tag-1:0]   w_tag;
  logic [WAYS-1:0]    w_hit_vec;
  logic               w_hit, w_found, w_vic_dirty, w_accept, w_up_resp;
  logic [WW-1:0]      w_hit_way, w_victim, w_wr_way, w_plru_way;
  logic [s_line-1:0]  w_hit_data, w_wr_data;
  logic               w_wr_en, w_plru_upd;
  logic               w_unused_ofs;

  assign w_index      = r_addr[s_offset +: s_index];
  assign w_tag        = r_addr[31 -: s_tag];
  assign w_accept     = (r_state == IDLE) && (up_read || up_write);
  assign w_unused_ofs = ^up_address[s_offset-1:0];

  // Heap-ordered tree: node n has children 2n and 2n+1; shifting in the node bit walks the tree.
  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-1:1] bits);
    logic [WW-1:0] n;
    n = WW'(1);
    for (int unsigned l = 0; l < WW; l++) n = WW'({n, bits[n]});
    return n;
  endfunction

  function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] bits, input logic [WW-1:0] way);
    logic [WAYS-1:1] res;
    logic [WW:0]     n;
    res = bits;
    n   = {1'b1, way};
    for (int unsigned l = 0; l < WW; l++) begin
      res[n[WW:1]] = ~n[0];
      n = {1'b0, n[WW:1]};
    end
    return res;
  endfunction

  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_hit_data = '0;
    w_victim   = plru_victim(r_plru[w_index]);
    w_found    = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      w_hit_vec[WW'(i)] = r_valid[w_index][WW'(i)] && (r_tag_q[WW'(i)] == w_tag);
      if (w_hit_vec[WW'(i)]) begin
        w_hit_way  = WW'(i);
        w_hit_data = r_data_q[WW'(i)];
      end
      if (!r_valid[w_index][WW'(i)] && !w_found) begin
        w_victim = WW'(i);
        w_found  = 1'b1;
      end
    end
    w_hit       = |w_hit_vec;
    w_vic_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];
  end

  always_comb begin
    w_next     = r_state;
    w_up_resp  = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_way   = w_victim;
    w_wr_data  = r_wdata;
    w_plru_upd = 1'b0;
    w_plru_way = w_victim;
    case (r_state)
      IDLE:   if (up_write || up_read) w_next = LOOKUP;
      LOOKUP: w_next = CHECK;
      CHECK: begin
        if (w_hit) begin
          w_up_resp  = 1'b1;
          w_plru_upd = 1'b1;
          w_plru_way = w_hit_way;
          w_wr_en    = r_is_write;
          w_wr_way   = w_hit_way;
          w_next     = IDLE;
        end else if (w_vic_dirty) begin
          w_next = WB;
        end else if (r_is_write) begin
          w_up_resp  = 1'b1;
          w_plru_upd = 1'b1;
          w_wr_en    = 1'b1;
          w_next     = IDLE;
        end else begin
          w_next = FILL;
        end
      end
      WB:   if (mem_resp) w_next = r_is_write ? CHECK : FILL;
      FILL: if (mem_resp) begin
        w_wr_en   = 1'b1;
        w_wr_way  = r_victim;
        w_wr_data = mem_rdata;
        w_next    = LOOKUP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_is_write  <= 1'b0;
      r_first     <= 1'b0;
      r_victim    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[s_index'(s)] <= '0;
        r_dirty[s_index'(s)] <= '0;
        r_plru[s_index'(s)]  <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_plru_upd) r_plru[w_index] <= plru_touch(r_plru[w_index], w_plru_way);
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr     <= up_address[31:s_offset];
          r_is_write <= up_write;
          r_first    <= 1'b1;
        end
        CHECK: begin
          r_first <= 1'b0;
          if (w_hit) begin
            if (r_is_write) r_dirty[w_index][w_hit_way] <= 1'b1;
          end else if (w_vic_dirty) begin
            r_victim    <= w_victim;
            r_mem_write <= 1'b1;
            r_mem_addr  <= {r_tag_q[w_victim], w_index, {s_offset{1'b0}}};
            r_mem_wdata <= r_data_q[w_victim];
          end else if (r_is_write) begin
            r_valid[w_index][w_victim] <= 1'b1;
            r_dirty[w_index][w_victim] <= 1'b1;
          end else begin
            r_victim   <= w_victim;
            r_mem_read <= 1'b1;
            r_mem_addr <= {r_addr, {s_offset{1'b0}}};
          end
        end
        WB: if (mem_resp) begin
          r_mem_write                <= 1'b0;
          r_dirty[w_index][r_victim] <= 1'b0;
          if (!r_is_write) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= {r_addr, {s_offset{1'b0}}};
          end
        end
        FILL: if (mem_resp) begin
          r_mem_read                 <= 1'b0;
          r_valid[w_index][r_victim] <= 1'b1;
          r_dirty[w_index][r_victim] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_wdata <= up_wdata;
    if (r_state == LOOKUP) begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        r_tag_q[WW'(i)]  <= r_tag[WW'(i)][w_index];
        r_data_q[WW'(i)] <= r_data[WW'(i)][w_index];
      end
    end
    if (w_wr_en) begin
      r_tag[w_wr_way][w_index]  <= w_tag;
      r_data[w_wr_way][w_index] <= w_wr_data;
    end
  end

  assign up_resp     = w_up_resp;
  assign up_rdata    = (w_up_resp && !r_is_write) ? w_hit_data : '0;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

`ifdef L2_PERF_CNT_EN
  logic [31:0] r_perf_hit, r_perf_miss, r_perf_wb;
  // r_first marks the initial CHECK of a request, excluding post-FILL and post-WB re-checks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
      r_perf_wb   <= '0;
    end else begin
      if (r_state == CHECK && r_first) begin
        if (w_hit) r_perf_hit  <= r_perf_hit + 32'd1;
        else       r_perf_miss <= r_perf_miss + 32'd1;
      end
      if (r_state == WB && mem_resp) r_perf_wb <= r_perf_wb + 32'd1;
    end
  end
  assign perf_hit  = r_perf_hit;
  assign perf_miss = r_perf_miss;
  assign perf_wb   = r_perf_wb;
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
  assign perf_wb   = '0;
`endif
endmodule

// File: tb/tb_l2_cache_nway.sv
// Self-checking bench for l2_cache_nway: directed transactions against a set/way cache model.
module tb_l2_cache_nway;
  localparam int W  = 4;
  localparam int TW = 23;
  localparam int LW = 256;

  logic          clk = 1'b0, rst = 1'b0;
  logic          up_read = 1'b0, up_write = 1'b0, mem_resp = 1'b0;
  logic [31:0]   up_address = '0;
  logic [LW-1:0] up_wdata = '0, mem_rdata = '0;
  logic [LW-1:0] up_rdata, mem_wdata;
  logic          up_resp, mem_read, mem_write;
  logic [31:0]   mem_address, perf_hit, perf_miss, perf_wb;

  l2_cache_nway #(.s_offset(5), .s_index(4), .WAYS(4)) dut (
    .clk(clk), .rst(rst), .up_read(up_read), .up_write(up_write),
    .up_address(up_address), .up_wdata(up_wdata), .up_rdata(up_rdata), .up_resp(up_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_wb(perf_wb)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cache model: per-set way contents plus a tree of "go right" flags over way ranges.
  bit            m_valid[16][W], m_dirty[16][W], m_node[16][W];
  logic [TW-1:0] m_tag[16][W];
  logic [LW-1:0] m_data[16][W];
  logic [LW-1:0] mmem[logic [31:0]];

  bit            e_hit, e_wb, e_fill, e_isread;
  logic [31:0]   e_wb_addr, e_fill_addr;
  logic [LW-1:0] e_wb_data, e_rdata;
  int            e_lat;

  function automatic logic [LW-1:0] mem_get(input logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic int plru_pick(input int s);
    int lo, hi, node, mid;
    lo = 0; hi = W; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_node[s][node]) begin lo = mid; node = 2 * node + 1; end
      else begin hi = mid; node = 2 * node; end
    end
    return lo;
  endfunction

  function automatic void plru_use(input int s, input int way);
    int lo, hi, node, mid;
    lo = 0; hi = W; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin m_node[s][node] = 1'b1; hi = mid; node = 2 * node; end
      else begin m_node[s][node] = 1'b0; lo = mid; node = 2 * node + 1; end
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < W; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_node[s][w] = 1'b0;
      end
  endfunction

  function automatic void predict(input bit wr, input logic [31:0] a, input logic [LW-1:0] d, input int L);
    int s, way;
    logic [TW-1:0] t;
    logic [31:0] la;
    s = int'(a[8:5]); t = a[31:9]; way = -1; la = {a[31:5], 5'b0};
    e_isread = !wr; e_wb = 1'b0; e_fill = 1'b0; e_lat = 2; e_rdata = '0;
    for (int i = 0; i < W; i++) if (m_valid[s][i] && m_tag[s][i] == t) way = i;
    e_hit = (way >= 0);
    if (way < 0) begin
      for (int i = W - 1; i >= 0; i--) if (!m_valid[s][i]) way = i;
      if (way < 0) way = plru_pick(s);
      if (m_valid[s][way] && m_dirty[s][way]) begin
        e_wb = 1'b1;
        e_wb_addr = {m_tag[s][way], a[8:5], 5'b0};
        e_wb_data = m_data[s][way];
        mmem[e_wb_addr] = e_wb_data;
        e_lat += L + 1;
      end
      m_valid[s][way] = 1'b1; m_tag[s][way] = t;
      if (wr) begin
        m_data[s][way] = d; m_dirty[s][way] = 1'b1;
      end else begin
        e_fill = 1'b1; e_fill_addr = la;
        m_data[s][way] = mem_get(la); m_dirty[s][way] = 1'b0;
        e_lat += L + 2;
      end
    end else if (wr) begin
      m_data[s][way] = d; m_dirty[s][way] = 1'b1;
    end
    if (!wr) e_rdata = m_data[s][way];
    plru_use(s, way);
  endfunction

  // Memory responder: answers after lat counted cycles of a held request.
  int lat = 1, wcnt = 0;
  initial forever begin
    @(negedge clk);
    if (mem_resp) begin
      mem_resp = 1'b0; wcnt = 0;
    end else if (mem_read || mem_write) begin
      wcnt++;
      if (wcnt >= lat) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_read ? mem_get(mem_address) : '0;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Compare process.
  bit            mon_on = 1'b0;
  int            cyc = 0, wb_seen = 0, fill_seen = 0;
  logic [LW-1:0] last_rdata = '0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (up_read || up_write) begin
        cyc++;
        if (mem_write) begin
          wb_seen++;
          chk("wb_expected", mem_write, e_wb);
          chk("wb_addr", mem_address, e_wb_addr);
          chk("wb_data", mem_wdata, e_wb_data);
          chk("wb_excl", mem_read, 1'b0);
        end
        if (mem_read) begin
          fill_seen++;
          chk("fill_expected", mem_read, e_fill);
          chk("fill_addr", mem_address, e_fill_addr);
        end
        if (up_resp) begin
          chk("latency", cyc, e_lat);
          chk("wb_happened", wb_seen > 0, e_wb);
          chk("fill_happened", fill_seen > 0, e_fill);
          if (e_isread) chk("rdata", up_rdata, e_rdata);
          last_rdata = up_rdata;
          cyc = 0; wb_seen = 0; fill_seen = 0;
        end
      end else begin
        chk("idle_resp", up_resp, 1'b0);
      end
    end
  end

  task automatic req(input bit wr, input bit rd, input logic [31:0] a, input logic [LW-1:0] d, input int L);
    int n;
    predict(wr, a, d, L);
    lat = L;
    @(negedge clk); #1;
    up_address = a; up_wdata = d; up_write = wr; up_read = rd;
    n = 0;
    do begin @(negedge clk); n++; end while (!up_resp && n < 200);
    if (!up_resp) chk("resp_timeout", up_resp, 1'b1);
    #1;
    up_read = 1'b0; up_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  logic [LW-1:0] lit, d0, d1, d2, d3, dx;
  int n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_up_resp", up_resp, 1'b0);
    chk("rst_up_rdata", up_rdata, '0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_address, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_perf", {perf_hit, perf_miss, perf_wb}, '0);
    @(negedge clk); rst = 1'b1;
    mon_on = 1'b1;

    // Cold read miss then hit.
    req(1'b0, 1'b1, 32'h0000_1000, '0, 5);
    lit = {8{32'hA5A5_1000}};
    chk("s1_data", last_rdata, lit);
    chk("s1_pin_fill", e_fill_addr, 32'h0000_1000);
    chk("s1_pin_lat", e_lat, 9);
    req(1'b0, 1'b1, 32'h0000_1000, '0, 5);
    chk("s1_pin_hit", e_hit, 1'b1);
    chk("s1_pin_hitlat", e_lat, 2);
`ifdef L2_PERF_CNT_EN
    chk("perf_hit", perf_hit, 32'd1);
    chk("perf_miss", perf_miss, 32'd1);
    chk("perf_wb", perf_wb, 32'd0);
`else
    chk("perf_off", {perf_hit, perf_miss, perf_wb}, '0);
`endif

    // Replacement order in set 0.
    do_reset();
    req(1'b0, 1'b1, 32'h000, '0, 2);
    req(1'b0, 1'b1, 32'h200, '0, 2);
    req(1'b0, 1'b1, 32'h400, '0, 2);
    req(1'b0, 1'b1, 32'h600, '0, 2);
    req(1'b0, 1'b1, 32'h000, '0, 2);
    chk("s2_pin_rehit", e_hit, 1'b1);
    req(1'b0, 1'b1, 32'h800, '0, 2);
    chk("s2_pin_way2", m_tag[0][2], 23'd4);
    req(1'b0, 1'b1, 32'h400, '0, 2);
    chk("s2_pin_400miss", e_hit, 1'b0);
    req(1'b0, 1'b1, 32'h600, '0, 2);
    chk("s2_pin_600hit", e_hit, 1'b1);

    // Write-allocate without fill, then dirty eviction.
    d0 = {8{32'hD0D0_0000}}; d1 = {8{32'hD1D1_1111}};
    d2 = {8{32'hD2D2_2222}}; d3 = {8{32'hD3D3_3333}};
    req(1'b1, 1'b0, 32'h020, d0, 3);
    req(1'b1, 1'b0, 32'h220, d1, 3);
    req(1'b1, 1'b0, 32'h420, d2, 3);
    req(1'b1, 1'b0, 32'h620, d3, 3);
    chk("s3_pin_nofill", {e_fill, e_wb}, 2'b00);
    req(1'b0, 1'b1, 32'h820, '0, 3);
    chk("s3_pin_wbaddr", e_wb_addr, 32'h0000_0020);
    chk("s3_pin_wbdata", e_wb_data, d0);
    chk("s3_pin_fill", e_fill_addr, 32'h0000_0820);
    chk("s3_pin_lat", e_lat, 11);

    // Read and write together: write wins.
    dx = {8{32'hCAFE_0040}};
    req(1'b1, 1'b1, 32'h040, dx, 2);
    chk("s4_pin_nofill", e_fill, 1'b0);
    req(1'b0, 1'b1, 32'h040, '0, 2);
    chk("s4_data", last_rdata, dx);
    req(1'b0, 1'b1, 32'h240, '0, 2);
    req(1'b0, 1'b1, 32'h440, '0, 2);
    req(1'b0, 1'b1, 32'h640, '0, 2);
    req(1'b0, 1'b1, 32'h840, '0, 2);
    chk("s4_pin_wbaddr", e_wb_addr, 32'h0000_0040);
    chk("s4_pin_wbdata", e_wb_data, dx);

    // Reset during a fill.
    mon_on = 1'b0; lat = 100000;
    @(negedge clk); #1;
    up_address = 32'h3000; up_read = 1'b1;
    n = 0;
    while (!mem_read && n < 50) begin @(negedge clk); n++; end
    chk("s5_mem_read_up", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("s5_mem_read_drop", mem_read, 1'b0);
    chk("s5_up_resp", up_resp, 1'b0);
    chk("s5_mem_addr", mem_address, '0);
    up_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    mon_on = 1'b1;
    req(1'b0, 1'b1, 32'h3000, '0, 2);
    chk("s5_pin_miss", e_fill, 1'b1);
    chk("s5_perf_after_rst_hit", perf_hit, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l2_cache_nway.md
# l2_cache_nway

Parametrised N-way set-associative, write-back, write-allocate L2 cache sitting between the L1 line interface and main memory. Generalises the fixed 4-way L2 datapath into a complete block with datapath plus controller. Way count and set count are configurable. Replacement is tree-PLRU with invalid-way-first selection. Full-line L1 writebacks allocate without a memory fill.

## Interface
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes
- s_index, 4, index bits; sets = 2**s_index
- WAYS, 4, associativity; power of two, ≥2
- s_tag, 32-s_offset-s_index, tag width (derived)
- s_line, 8*2**s_offset, line width in bits (derived)
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- up_read  in  1  line read request; held until up_resp
- up_write  in  1  full-line write request; held until up_resp
- up_address  in  32  request address; offset bits ignored
- up_wdata  in  s_line  write line
- up_rdata  out  s_line  read line; valid only while up_resp=1
- up_resp  out  1  one-cycle completion pulse
- mem_read  out  1  memory line read; held until mem_resp
- mem_write  out  1  memory line write; held until mem_resp
- mem_address  out  32  line-aligned memory address
- mem_wdata  out  s_line  writeback line
- mem_rdata  in  s_line  fill line; valid with mem_resp
- mem_resp  in  1  memory completion pulse
- perf_hit, perf_miss, perf_wb  out  32 each  event counters (see Configuration)

## Operation
- FSM states: IDLE, LOOKUP, CHECK, WB, FILL.
- IDLE: if up_write or up_read, latch address, op and wdata → LOOKUP. up_write wins if both are high.
- LOOKUP: index = addr[s_offset+s_index-1:s_offset] is presented to the synchronous-read arrays → CHECK.
- CHECK, hit (valid && tag match in exactly one way):
  - read: up_rdata = way line, up_resp=1.
  - write: write the line, set dirty, up_resp=1.
  - PLRU is updated in both cases → IDLE.
- CHECK, miss: victim = lowest-index invalid way, else the PLRU victim.
  - victim valid && dirty → WB.
  - else if op=write: write the line into the victim, set tag/valid/dirty, update PLRU, up_resp=1 → IDLE. No memory traffic.
  - else → FILL.
- WB: mem_write=1, mem_address = {victim_tag, index, 0}, mem_wdata = victim line. On mem_resp: clear victim dirty.
  - read → FILL.
  - write → CHECK. The re-check takes the clean-victim path.
- FILL: mem_read=1, mem_address = {addr[31:s_offset], 0}. On mem_resp: write mem_rdata into victim, set tag and valid, clear dirty → LOOKUP. The re-lookup hits.
- Tree-PLRU, WAYS-1 bits per set:
  - Victim walk: at each node, bit 0 → left subtree, bit 1 → right subtree.
  - On an access, each node on the path is set to point away from the accessed way (accessed left → 1).
- Arrays and reset:
  - Valid, dirty and PLRU are flop arrays, cleared by rst.
  - Tag and data arrays are not reset.
- Outputs at reset: up_resp=0, up_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, perf_*=0.

## Timing
- Hit latency: the request is sampled at edge E0 (IDLE). up_resp is high during the cycle after E1 (CHECK). FSM is back in IDLE after E2.
- A request held across the up_resp edge is not re-accepted, because the FSM is in CHECK at that edge.
- Miss latency: 3 cycles plus the memory wait for each WB/FILL transaction, plus 2 cycles for the re-lookup.
- mem_read, mem_write, mem_address and mem_wdata are registered. They are stable from assertion until the mem_resp cycle and deassert the cycle after mem_resp. They are never both high.
- mem_resp outside WB/FILL is ignored.
- rst low at any point (including mid-WB or mid-FILL):
  - all outputs drop immediately;
  - FSM → IDLE;
  - the in-flight transaction is abandoned and no up_resp is issued.

## Configuration
- L2_PERF_CNT_EN defined: perf_hit, perf_miss and perf_wb are 32-bit wrapping counters.
  - perf_hit increments on each CHECK hit that is not a post-FILL re-lookup.
  - perf_miss increments on each first CHECK miss.
  - perf_wb increments on each WB mem_resp.
  - All three are cleared by rst.
- L2_PERF_CNT_EN undefined: perf_* are constant 0 and no counter flops exist.

## Test plan
- Cold read 0x00001000, mem_rdata=A after 5 cycles → mem_read at 0x00001000, up_resp with A. Re-read → up_resp 2 cycles after acceptance, with no mem_read.
- Read 0x000, 0x200, 0x400, 0x600, then 0x000 again, then 0x800 → fills land in ways 0,1,2,3. The 0x800 fill evicts way 2, so a following 0x400 read misses and 0x600 hits.
- Writes of D0..D3 to 0x020, 0x220, 0x420, 0x620 (all write-miss):
  - required: no memory traffic, one up_resp each;
  - then read 0x820 → mem_write to 0x00000020 with D0, followed by mem_read at 0x00000820.
- up_read and up_write both high at 0x040 → treated as a write: data stored, dirty set, no mem_read.
- rst low while mem_read=1 → mem_read and up_resp are 0 immediately. After release, a read to the same address misses again.
- L2_PERF_CNT_EN defined, run scenario 1 → perf_hit=1, perf_miss=1, perf_wb=0. Undefined → all 0.
